pe_os_fp16: RTL and testbench

Output-stationary fp16 processing element for the systolic array, built directly around one `mac_unit` instance, which computes a*b+c combinationally. It forwards west operands east and north operands south through one register stage each. It accumulates `acc = in_a*in_b + acc` for a programmed number of valid operand pairs per tile, then presents the finished tile result to the readout logic. The PE is the sequential stage that feeds `mac_unit` its operands and consumes its output every cycle.

---
 rtl/pe_os_fp16.sv | 149 ++++++++++++++
 tb/tb_pe_os_fp16.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pe_os_fp16.sv
// pe_os_fp16: output-stationary fp16 PE around a fused mac_unit; optional sticky NaN flag under PE_NAN_STICKY_EN
module mac_unit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [15:0] i_c,
  output logic [15:0] o_y
);
  logic [4:0] w_ea, w_eb, w_ec, w_xa, w_xb, w_xc;
  logic [10:0] w_ma, w_mb, w_mc, w_mant;
  logic [21:0] w_mp;
  logic [5:0] w_shp, w_shc;
  logic [80:0] w_p, w_c, w_s;
  logic [6:0] w_pos, w_sh;
  logic [16:0] w_pk;
  logic w_sp, w_sc, w_pge, w_sign, w_rnd, w_stk, w_inc, w_ovf;
  logic w_anan, w_bnan, w_cnan, w_ainf, w_binf, w_cinf, w_azero, w_bzero, w_nan;
  assign w_ea = i_a[14:10];
  assign w_eb = i_b[14:10];
  assign w_ec = i_c[14:10];
  assign w_xa = (w_ea == 5'd0) ? 5'd1 : w_ea;
  assign w_xb = (w_eb == 5'd0) ? 5'd1 : w_eb;
  assign w_xc = (w_ec == 5'd0) ? 5'd1 : w_ec;
  assign w_ma = {|w_ea, i_a[9:0]};
  assign w_mb = {|w_eb, i_b[9:0]};
  assign w_mc = {|w_ec, i_c[9:0]};
  assign w_mp = {11'd0, w_ma} * {11'd0, w_mb};
  // exact fixed point with LSB = 2^-48: covers the smallest product and the largest finite product
  assign w_shp = {1'b0, w_xa} + {1'b0, w_xb} - 6'd2;
  assign w_shc = {1'b0, w_xc} + 6'd23;
  assign w_p = {59'd0, w_mp} << w_shp;
  assign w_c = {70'd0, w_mc} << w_shc;
  assign w_sp = i_a[15] ^ i_b[15];
  assign w_sc = i_c[15];
  assign w_pge = w_p >= w_c;
  assign w_s = (w_sp == w_sc) ? w_p + w_c : (w_pge ? w_p - w_c : w_c - w_p);
  assign w_sign = (w_s == 81'd0) ? (w_sp & w_sc) : (w_pge ? w_sp : w_sc);
  // leading-one position of the exact sum
  always_comb begin
    w_pos = 7'd0;
    for (int i = 0; i < 81; i++) if (w_s[i]) w_pos = 7'(i);
  end
  // bit 34 is 2^-14 (smallest normal); below that the LSB is pinned at 2^-24
  assign w_sh = (w_pos >= 7'd34) ? w_pos - 7'd10 : 7'd24;
  assign w_mant = 11'(w_s >> w_sh);
  assign w_rnd = w_s[w_sh - 7'd1];
  assign w_stk = |(w_s & ((81'd1 << (w_sh - 7'd1)) - 81'd1));
  assign w_inc = w_rnd & (w_stk | w_mant[0]);
  // hidden bit adds into the exponent field, so a rounding carry renormalises for free
  assign w_pk = ((w_pos >= 7'd34) ? ({10'd0, w_pos - 7'd34} << 10) : 17'd0) + {6'd0, w_mant} + {16'd0, w_inc};
  assign w_ovf = w_pk >= 17'h07C00;
  assign w_anan = (w_ea == 5'h1F) & |i_a[9:0];
  assign w_bnan = (w_eb == 5'h1F) & |i_b[9:0];
  assign w_cnan = (w_ec == 5'h1F) & |i_c[9:0];
  assign w_ainf = (w_ea == 5'h1F) & ~|i_a[9:0];
  assign w_binf = (w_eb == 5'h1F) & ~|i_b[9:0];
  assign w_cinf = (w_ec == 5'h1F) & ~|i_c[9:0];
  assign w_azero = ~|i_a[14:0];
  assign w_bzero = ~|i_b[14:0];
  assign w_nan = w_anan | w_bnan | w_cnan | (w_ainf & w_bzero) | (w_binf & w_azero) |
                 ((w_ainf | w_binf) & w_cinf & (w_sp != w_sc));
  assign o_y = w_nan ? 16'h7E00 :
               (w_ainf | w_binf) ? {w_sp, 15'h7C00} :
               w_cinf ? {w_sc, 15'h7C00} :
               w_ovf ? {w_sign, 15'h7C00} : {w_sign, w_pk[14:0]};
endmodule

module pe_os_fp16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_a,
  input  logic        in_a_vld,
  input  logic [15:0] in_b,
  input  logic        in_b_vld,
  input  logic        clr,
  input  logic [7:0]  len,
  output logic [15:0] out_a,
  output logic        out_a_vld,
  output logic [15:0] out_b,
  output logic        out_b_vld,
  output logic [15:0] result,
  output logic        result_vld,
  output logic        proto_err,
  output logic        nan_flag
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;
  state_t r_state, w_state_nx;
  logic [15:0] r_acc, w_mac;
  logic [7:0] r_cnt, r_len, w_cnt_nx;
  logic r_perr, w_acc_en, w_one;
  mac_unit u_mac (.i_a(in_a), .i_b(in_b), .i_c(r_acc), .o_y(w_mac));
  assign w_acc_en = (r_state == S_ACC) & in_a_vld & in_b_vld & ~clr;
  assign w_one = (r_state == S_ACC) & (in_a_vld ^ in_b_vld) & ~clr;
  assign w_cnt_nx = r_cnt + 8'd1;
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  end
  // clr restarts a tile from any state; the len_q-th accepted pair ends it
  always_comb begin
    w_state_nx = r_state;
    w_state_nx = clr ? ((len == 8'd0) ? S_DONE : S_ACC) :
                 (w_acc_en && w_cnt_nx == r_len) ? S_DONE : r_state;
  end
  // forwarding registers plus accumulator, counter and pairing-error datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a <= 16'h0000;
      out_a_vld <= 1'b0;
      out_b <= 16'h0000;
      out_b_vld <= 1'b0;
      r_acc <= 16'h0000;
      r_cnt <= 8'd0;
      r_len <= 8'd0;
      r_perr <= 1'b0;
    end else begin
      out_a <= in_a;
      out_a_vld <= in_a_vld;
      out_b <= in_b;
      out_b_vld <= in_b_vld;
      if (clr) begin
        r_acc <= 16'h0000;
        r_cnt <= 8'd0;
        r_len <= len;
        r_perr <= 1'b0;
      end else begin
        if (w_acc_en) begin
          r_acc <= w_mac;
          r_cnt <= w_cnt_nx;
        end
        if (w_one) r_perr <= 1'b1;
      end
    end
  end
  assign result = r_acc;
  assign result_vld = r_state == S_DONE;
  assign proto_err = r_perr;
`ifdef PE_NAN_STICKY_EN
  logic r_nan;
  // sticky NaN seen on any accumulating update of the current tile
  always_ff @(posedge clk) begin
    if (rst || clr) r_nan <= 1'b0;
    else if (w_acc_en && w_mac[14:10] == 5'h1F && |w_mac[9:0]) r_nan <= 1'b1;
  end
  assign nan_flag = r_nan;
`else
  assign nan_flag = 1'b0;
`endif
endmodule

// File: tb/tb_pe_os_fp16.sv
// tb_pe_os_fp16: directed self-checking bench for pe_os_fp16
module tb_pe_os_fp16;
  logic clk = 1'b0, rst = 1'b1, in_a_vld = 1'b0, in_b_vld = 1'b0, clr = 1'b0;
  logic [15:0] in_a = 16'h0, in_b = 16'h0;
  logic [7:0] len = 8'd0;
  logic [15:0] out_a, out_b, result;
  logic out_a_vld, out_b_vld, result_vld, proto_err, nan_flag;
  int errors = 0, checks = 0;
`ifdef PE_NAN_STICKY_EN
  localparam logic NAN_EN = 1'b1;
`else
  localparam logic NAN_EN = 1'b0;
`endif
  pe_os_fp16 dut (.clk(clk), .rst(rst), .in_a(in_a), .in_a_vld(in_a_vld), .in_b(in_b), .in_b_vld(in_b_vld),
    .clr(clr), .len(len), .out_a(out_a), .out_a_vld(out_a_vld), .out_b(out_b), .out_b_vld(out_b_vld),
    .result(result), .result_vld(result_vld), .proto_err(proto_err), .nan_flag(nan_flag));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic c, input logic [7:0] l, input logic av, input logic [15:0] a,
                       input logic bv, input logic [15:0] b);
    clr = c; len = l; in_a_vld = av; in_a = a; in_b_vld = bv; in_b = b;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, ".out_a"}, out_a, 16'h0);
    chk({tag, ".out_a_vld"}, 16'(out_a_vld), 16'h0);
    chk({tag, ".out_b"}, out_b, 16'h0);
    chk({tag, ".out_b_vld"}, 16'(out_b_vld), 16'h0);
    chk({tag, ".result"}, result, 16'h0);
    chk({tag, ".result_vld"}, 16'(result_vld), 16'h0);
    chk({tag, ".proto_err"}, 16'(proto_err), 16'h0);
    chk({tag, ".nan_flag"}, 16'(nan_flag), 16'h0);
  endtask
  initial begin
    drive(1'b1, 8'(($urandom)), 1'b1, 16'($urandom), 1'b1, 16'($urandom));
    step();
    drive(1'b1, 8'(($urandom)), 1'b1, 16'($urandom), 1'b0, 16'($urandom));
    step();
    all_zero("reset");
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b1, 16'h3C00, 1'b1, 16'h4000);
    step();
    chk("idle_pair.result", result, 16'h0000);
    chk("idle_pair.vld", 16'(result_vld), 16'h0);
    chk("idle_pair.fwd", out_a, 16'h3C00);
    drive(1'b0, 8'd0, 1'b1, 16'h3C00, 1'b0, 16'h4000);
    step();
    chk("idle_one.perr", 16'(proto_err), 16'h0);
    drive(1'b1, 8'd2, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("tile.clr_vld", 16'(result_vld), 16'h0);
    drive(1'b0, 8'd0, 1'b1, 16'h3C00, 1'b1, 16'h4000);
    step();
    chk("tile.p1", result, 16'h4000);
    chk("tile.p1_vld", 16'(result_vld), 16'h0);
    drive(1'b0, 8'd0, 1'b1, 16'h4000, 1'b1, 16'h4000);
    step();
    chk("tile.p2", result, 16'h4600);
    chk("tile.p2_vld", 16'(result_vld), 16'h1);
    step();
    chk("tile.p3", result, 16'h4600);
    chk("tile.p3_vld", 16'(result_vld), 16'h1);
    drive(1'b1, 8'd5, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    drive(1'b0, 8'd0, 1'b1, 16'h1234, 1'b0, 16'hABCD);
    step();
    chk("fwd.out_a", out_a, 16'h1234);
    chk("fwd.out_a_vld", 16'(out_a_vld), 16'h1);
    chk("fwd.out_b", out_b, 16'hABCD);
    chk("fwd.out_b_vld", 16'(out_b_vld), 16'h0);
    chk("fwd.perr", 16'(proto_err), 16'h1);
    chk("fwd.result", result, 16'h0000);
    drive(1'b1, 8'd1, 1'b1, 16'h4200, 1'b1, 16'h4000);
    step();
    chk("clrpri.result", result, 16'h0000);
    chk("clrpri.perr", 16'(proto_err), 16'h0);
    chk("clrpri.vld", 16'(result_vld), 16'h0);
    drive(1'b0, 8'd0, 1'b1, 16'h3800, 1'b1, 16'h4000);
    step();
    chk("clrpri.p1", result, 16'h3C00);
    chk("clrpri.p1_vld", 16'(result_vld), 16'h1);
    drive(1'b1, 8'd2, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    drive(1'b0, 8'd0, 1'b1, 16'h4000, 1'b1, 16'h4000);
    step();
    chk("sub.p1", result, 16'h4400);
    drive(1'b0, 8'd0, 1'b1, 16'hBC00, 1'b1, 16'h4000);
    step();
    chk("sub.p2", result, 16'h4000);
    chk("sub.vld", 16'(result_vld), 16'h1);
    drive(1'b1, 8'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("len0.vld", 16'(result_vld), 16'h1);
    chk("len0.result", result, 16'h0000);
    drive(1'b1, 8'd3, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("len3.vld", 16'(result_vld), 16'h0);
    drive(1'b0, 8'd0, 1'b1, 16'h3C00, 1'b1, 16'h3C00);
    step();
    chk("len3.p1", result, 16'h3C00);
    drive(1'b0, 8'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    rst = 1'b1;
    step();
    all_zero("midrst");
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b1, 16'h4000, 1'b1, 16'h4000);
    step();
    chk("midrst.idle", result, 16'h0000);
    drive(1'b1, 8'd2, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    drive(1'b0, 8'd0, 1'b1, 16'h7E00, 1'b1, 16'h3C00);
    step();
    chk("nan.p1", result, 16'h7E00);
    chk("nan.f1", 16'(nan_flag), 16'(NAN_EN));
    drive(1'b0, 8'd0, 1'b1, 16'h3C00, 1'b1, 16'h3C00);
    step();
    chk("nan.vld", 16'(result_vld), 16'h1);
    chk("nan.f2", 16'(nan_flag), 16'(NAN_EN));
    drive(1'b0, 8'd0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("nan.hold", 16'(nan_flag), 16'(NAN_EN));
    drive(1'b1, 8'd1, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    chk("nan.clr", 16'(nan_flag), 16'h0);
    chk("nan.clr_result", result, 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
